// File: rtl/shift_sequencer.sv
// shift_sequencer: universal shift register driven by a small step sequencer.
// One accepted start command runs a shift/rotate operation for 'count' steps,
// one step per enabled clock, then emits a single-cycle done pulse.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         clock enable; low holds all state and suppresses done
//   start      command strobe, sampled in IDLE
//   op         operation code (0 clear, 1 load, 2..7 shift/rotate)
//   count      number of shift steps for ops 2..7
//   load_data  parallel load value for op 1
//   ser_in     serial input for op 5, sampled on each step
//   q          register contents
//   ser_out    bit shifted out on the most recent step
//   busy       high while a multi-step run is in progress
//   done       one-cycle completion pulse
module shift_sequencer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [CNT_W-1:0] count,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    localparam int unsigned N = WIDTH - 1;

    state_e           state;
    logic [2:0]       op_r;
    logic [CNT_W-1:0] rem;

    logic [WIDTH-1:0] step_q;
    logic             step_so;

    // Next register value and shifted-out bit for one step of the latched op.
    always_comb begin
        step_q  = q;
        step_so = ser_out;
        case (op_r)
            3'd2: begin
                step_q  = {1'b0, q[N:1]};
                step_so = q[0];
            end
            3'd3: begin
                step_q  = {q[N-1:0], 1'b0};
                step_so = q[N];
            end
            3'd4: begin
                step_q  = {q[N], q[N:1]};
                step_so = q[0];
            end
            3'd5: begin
                step_q  = {ser_in, q[N:1]};
                step_so = q[0];
            end
            3'd6: begin
                step_q  = {q[0], q[N:1]};
                step_so = q[0];
            end
            3'd7: begin
                step_q  = {q[N-1:0], q[N]};
                step_so = q[N];
            end
            default: begin
                step_q  = q;
                step_so = ser_out;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= StIdle;
            op_r    <= '0;
            rem     <= '0;
            q       <= '0;
            ser_out <= 1'b0;
            done    <= 1'b0;
        end else if (!en) begin
            // Hold everything; a pending done pulse is dropped, not delayed.
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        case (op)
                            3'd0: begin
                                q    <= '0;
                                done <= 1'b1;
                            end
                            3'd1: begin
                                q    <= load_data;
                                done <= 1'b1;
                            end
                            default: begin
                                if (count == '0) begin
                                    done <= 1'b1;
                                end else begin
                                    op_r  <= op;
                                    rem   <= count;
                                    state <= StRun;
                                end
                            end
                        endcase
                    end
                end
                StRun: begin
                    q       <= step_q;
                    ser_out <= step_so;
                    rem     <= rem - CNT_W'(1);
                    if (rem == CNT_W'(1)) begin
                        state <= StIdle;
                        done  <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign busy = (state == StRun);

endmodule
